// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter with a byte TX FIFO.
// DATA at addr_i[2]=0 (write pushes a byte), STATUS at addr_i[2]=1.
module uart_tx_device #(
   parameter int CLK_DIVISOR = 434,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   input  logic [3:0]  write_mask_i,
   output logic [31:0] read_data_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLK_DIVISOR);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIVISOR - 1);
   localparam logic [CW-1:0] BONE   = CW'(1);
   localparam logic [AW:0]   PONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] baud;
   logic [CW-1:0] baud_n;
   logic [2:0]    bit_idx;
   logic [2:0]    bit_idx_n;
   logic [7:0]    shift;
   logic [7:0]    shift_n;
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [AW:0]   count;
   logic [7:0]    count8;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [7:0]    head;
   logic          overflow;
   logic          empty;
   logic          full;
   logic          busy;
   logic          pop;
   logic          push;
   logic          data_wr;
   logic          status_wr;
   logic          tick;
   logic          tx_n;
   logic [31:0]   status;
   logic          unused;

   assign unused = ^{addr_i[31:3], addr_i[1:0],
                     write_data_i[31:8], write_mask_i[3:1]};

   assign count  = wptr - rptr;
   assign count8 = 8'(count);
   assign empty  = (wptr == rptr);
   assign full   = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
   assign busy   = (state != IDLE);
   assign head   = mem[rptr[AW-1:0]];
   assign tick   = (baud == '0);

   assign data_wr   = write_mask_i[0] && !addr_i[2];
   assign status_wr = write_mask_i[0] && addr_i[2];
   // Full is judged on pre-edge state: a same-cycle pop never rescues a write.
   assign push      = data_wr && !full;

   assign status = {16'h0, count8, 4'h0,
                    overflow, empty, full, busy};

   assign tx_n = (state == START) ? 1'b0 :
                 (state == DATA)  ? shift[0] : 1'b1;

   always_comb begin
      state_n   = state;
      baud_n    = baud;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               baud_n  = RELOAD;
               state_n = START;
            end
         end
         START: begin
            baud_n = tick ? RELOAD : baud - BONE;
            if (tick) begin
               state_n = DATA;
            end
         end
         DATA: begin
            baud_n = tick ? RELOAD : baud - BONE;
            if (tick) begin
               shift_n   = {1'b0, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end
            end
         end
         STOP: begin
            baud_n = tick ? RELOAD : baud - BONE;
            if (tick) begin
               // Chain straight into the next start bit when more is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = head;
                  state_n = START;
               end else begin
                  baud_n  = '0;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state       <= IDLE;
         baud        <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         wptr        <= '0;
         rptr        <= '0;
         overflow    <= 1'b0;
         tx_o        <= 1'b1;
         irq_o       <= 1'b0;
         read_data_o <= '0;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         if (push) begin
            wptr <= wptr + PONE;
         end
         if (pop) begin
            rptr <= rptr + PONE;
         end
         if (data_wr && full) begin
            overflow <= 1'b1;
         end else if (status_wr && write_data_i[3]) begin
            overflow <= 1'b0;
         end
         tx_o        <= tx_n;
         irq_o       <= empty && !busy;
         read_data_o <= addr_i[2] ? status : 32'h0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wptr[AW-1:0]] <= write_data_i[7:0];
      end
   end

endmodule

// File: tb/tb_uart_tx_device.sv
// Bench for uart_tx_device: register vector table, a serial-line
// monitor with a byte scoreboard, and multi-cycle sequences.
module tb_uart_tx_device;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;
   localparam logic [31:0] A_DATA = 32'hFF000008;
   localparam logic [31:0] A_STAT = 32'hFF00000C;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [31:0] addr_i;
   logic [31:0] write_data_i;
   logic [3:0]  write_mask_i;
   logic [31:0] read_data_o;
   logic        tx_o;
   logic        irq_o;

   int total = 0;
   int bad   = 0;
   int nrx   = 0;
   int cyc   = 0;
   logic [7:0] sb[$];
   int starts[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] rd;
      logic        irq;
   } vec_t;

   vec_t vecs[7];

   uart_tx_device #(
      .CLK_DIVISOR(DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .addr_i      (addr_i),
      .write_data_i(write_data_i),
      .write_mask_i(write_mask_i),
      .read_data_o (read_data_o),
      .tx_o        (tx_o),
      .irq_o       (irq_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic bus(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  m);
      addr_i       = a;
      write_data_i = d;
      write_mask_i = m;
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      repeat (n) bus(A_DATA, 32'h0, 4'h0);
   endtask

   task automatic wr(input logic [7:0] b, input logic acc);
      bus(A_DATA, {24'hFFFFFF, b}, 4'b0001);
      if (acc) sb.push_back(b);
   endtask

   task automatic drain(input int max);
      int k = 0;
      while (!(irq_o === 1'b1 && sb.size() == 0) && k < max) begin
         bus(A_DATA, 32'h0, 4'h0);
         k++;
      end
      check("drain_done",
            32'(irq_o === 1'b1 && sb.size() == 0), 32'd1);
   endtask

   initial begin : monitor
      logic [9:0] fr;
      logic       aborted;
      logic       unstable;
      logic [7:0] want;
      forever begin
         @(negedge clk_i);
         if (reset_i === 1'b1 && tx_o === 1'b0) begin
            starts.push_back(cyc);
            aborted  = 1'b0;
            unstable = 1'b0;
            fr       = '0;
            for (int b = 0; b < 10; b++) begin
               for (int c = 0; c < DIV; c++) begin
                  if (b != 0 || c != 0) @(negedge clk_i);
                  if (reset_i !== 1'b1) aborted = 1'b1;
                  if (c == 0) fr[b] = tx_o;
                  else if (tx_o !== fr[b]) unstable = 1'b1;
               end
            end
            if (!aborted) begin
               nrx++;
               check("bit_stable", 32'(unstable), 32'd0);
               check("frame_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  want = sb.pop_front();
                  check("frame_bits", 32'(fr),
                        {22'h0, 1'b1, want, 1'b0});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin : main
      int n0;
      int t0;
      vecs[0] = '{A_STAT,       32'h0,        4'b0000, 32'h4, 1'b1};
      vecs[1] = '{A_DATA,       32'h5A,       4'b1110, 32'h0, 1'b1};
      vecs[2] = '{32'h00000004, 32'h0,        4'b0000, 32'h4, 1'b1};
      vecs[3] = '{A_STAT,       32'hFFFFFFF7, 4'b0001, 32'h4, 1'b1};
      vecs[4] = '{32'hFFFFFFFB, 32'hFFFFFF00, 4'b1110, 32'h0, 1'b1};
      vecs[5] = '{A_STAT,       32'h8,        4'b0001, 32'h4, 1'b1};
      vecs[6] = '{A_STAT,       32'h0,        4'b1111, 32'h4, 1'b1};

      addr_i       = 32'h0;
      write_data_i = 32'h0;
      write_mask_i = 4'h0;
      reset_i      = 1'b1;
      #1 reset_i   = 1'b0;
      #1;
      check("rst_tx", 32'(tx_o), 32'd1);
      check("rst_rd", read_data_o, 32'h0);
      check("rst_irq", 32'(irq_o), 32'd0);
      repeat (3) @(negedge clk_i);
      check("rst_irq_held", 32'(irq_o), 32'd0);
      reset_i = 1'b1;
      idle(1);
      check("irq_after_reset", 32'(irq_o), 32'd1);
      check("tx_idle", 32'(tx_o), 32'd1);

      for (int i = 0; i < 7; i++) begin
         bus(vecs[i].addr, vecs[i].wdata, vecs[i].mask);
         check($sformatf("vec%0d_rd", i), read_data_o, vecs[i].rd);
         check($sformatf("vec%0d_irq", i), 32'(irq_o), 32'(vecs[i].irq));
      end

      // single byte 0xA5
      starts.delete();
      n0 = nrx;
      wr(8'hA5, 1'b1);
      t0 = cyc;
      bus(A_STAT, 32'h0, 4'h0);
      check("single_stat_queued", read_data_o, 32'h100);
      check("single_irq_drop", 32'(irq_o), 32'd0);
      bus(A_STAT, 32'h0, 4'h0);
      check("single_stat_busy", read_data_o, 32'h5);
      check("single_start_low", 32'(tx_o), 32'd0);
      idle(38);
      check("single_irq_mid", 32'(irq_o), 32'd0);
      bus(A_STAT, 32'h0, 4'h0);
      check("single_stat_stop", read_data_o, 32'h5);
      check("single_irq_stop", 32'(irq_o), 32'd0);
      bus(A_STAT, 32'h0, 4'h0);
      check("single_stat_idle", read_data_o, 32'h4);
      check("single_irq_done", 32'(irq_o), 32'd1);
      check("single_nrx", 32'(nrx - n0), 32'd1);
      check("single_starts", 32'(starts.size()), 32'd1);
      if (starts.size() > 0)
         check("single_latency", 32'(starts[0] - t0), 32'd2);

      // back-to-back 0x55, 0x0F
      starts.delete();
      n0 = nrx;
      wr(8'h55, 1'b1);
      wr(8'h0F, 1'b1);
      bus(A_STAT, 32'h0, 4'h0);
      check("b2b_count1", read_data_o, 32'h101);
      idle(38);
      bus(A_STAT, 32'h0, 4'h0);
      check("b2b_count1_stop", read_data_o, 32'h101);
      bus(A_STAT, 32'h0, 4'h0);
      check("b2b_count0", read_data_o, 32'h5);
      drain(200);
      check("b2b_nrx", 32'(nrx - n0), 32'd2);
      check("b2b_starts", 32'(starts.size()), 32'd2);
      if (starts.size() == 2)
         check("b2b_gap", 32'(starts[1] - starts[0]), 32'd40);

      // overflow: 0x01 popped, 0x02..0x05 fill, 0x06 dropped
      n0 = nrx;
      for (int i = 1; i <= 6; i++) wr(8'(i), i <= 5);
      bus(A_STAT, 32'h0, 4'h0);
      check("ovf_stat", read_data_o, 32'h40B);
      bus(A_STAT, 32'hFFFFFFF7, 4'b0001);
      check("ovf_stat2", read_data_o, 32'h40B);
      bus(A_STAT, 32'h0, 4'h0);
      check("ovf_kept", read_data_o, 32'h40B);
      bus(A_STAT, 32'h8, 4'b0001);
      check("ovf_before_clr", read_data_o, 32'h40B);
      bus(A_STAT, 32'h0, 4'h0);
      check("ovf_cleared", read_data_o, 32'h403);
      drain(400);
      check("ovf_nrx", 32'(nrx - n0), 32'd5);
      bus(A_STAT, 32'h0, 4'h0);
      check("ovf_final", read_data_o, 32'h4);

      // wrap-around: 10 bytes in bursts of 3
      n0 = nrx;
      for (int k = 0; k < 10; k += 3) begin
         for (int i = k; i < k + 3 && i < 10; i++)
            wr(8'(8'h10 + i), 1'b1);
         drain(300);
      end
      check("wrap_nrx", 32'(nrx - n0), 32'd10);
      bus(A_STAT, 32'h0, 4'h0);
      check("wrap_stat", read_data_o, 32'h4);

      // reset during DATA bit 3 with 3 bytes queued
      n0 = nrx;
      wr(8'hC3, 1'b1);
      wr(8'h11, 1'b1);
      wr(8'h22, 1'b1);
      wr(8'h33, 1'b1);
      idle(16);
      check("mid_tx_bit3", 32'(tx_o), 32'd0);
      reset_i = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_tx", 32'(tx_o), 32'd1);
      check("mid_rst_rd", read_data_o, 32'h0);
      check("mid_rst_irq", 32'(irq_o), 32'd0);
      repeat (3) @(negedge clk_i);
      reset_i = 1'b1;
      bus(A_STAT, 32'h0, 4'h0);
      check("mid_stat", read_data_o, 32'h4);
      check("mid_irq", 32'(irq_o), 32'd1);
      idle(60);
      check("mid_no_frames", 32'(nrx - n0), 32'd0);
      bus(A_STAT, 32'h0, 4'h0);
      check("mid_stat_end", read_data_o, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
